euler_mult_sum: RTL and testbench



---
 rtl/euler_mult_sum.sv | 123 ++++++++++++
 tb/tb_euler_mult_sum.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/euler_mult_sum.sv
// euler_mult_sum: sums every n in [1, max_value) that is a multiple of div_a
// or div_b. A divisor of 0 disables that divisor. Only residue counters are
// used, so there are no dividers or multipliers.
// Start/busy/done handshake, enable stalling, sticky overflow.
// Optional feature macro: EULER_SUM_COUNT_EN adds the match_count output.
module euler_mult_sum #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned SUM_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic [CNT_W-1:0] max_value,
    input  logic [CNT_W-1:0] div_a,
    input  logic [CNT_W-1:0] div_b,
    output logic             busy,
    output logic             results_valid,
    output logic [SUM_W-1:0] results,
`ifdef EULER_SUM_COUNT_EN
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;

    logic [CNT_W-1:0] max_l;
    logic [CNT_W-1:0] div_a_l;
    logic [CNT_W-1:0] div_b_l;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ra;
    logic [CNT_W-1:0] rb;

    logic             accept;
    logic             step;
    logic             hit_a;
    logic             hit_b;
    logic             match;
    logic [SUM_W:0]   sum_ext;

    // Handshake qualifiers, residue match and the widened add
    always_comb begin
        accept  = start && (state == IDLE || state == DONE);
        step    = (state == RUN) && enable && (cnt < max_l);
        hit_a   = (ra == div_a_l);
        hit_b   = (rb == div_b_l);
        match   = ((div_a_l != '0) && hit_a) || ((div_b_l != '0) && hit_b);
        sum_ext = {1'b0, results} + {{(SUM_W + 1 - CNT_W){1'b0}}, cnt};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (enable && !(cnt < max_l)) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy          = (state == RUN);
        results_valid = (state == DONE);
    end

    // Operand latch, counters and accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            max_l    <= '0;
            div_a_l  <= '0;
            div_b_l  <= '0;
            cnt      <= '0;
            ra       <= '0;
            rb       <= '0;
            results  <= '0;
            overflow <= 1'b0;
`ifdef EULER_SUM_COUNT_EN
            match_count <= '0;
`endif
        end else if (accept) begin
            max_l    <= max_value;
            div_a_l  <= div_a;
            div_b_l  <= div_b;
            cnt      <= CNT_W'(1);
            ra       <= CNT_W'(1);
            rb       <= CNT_W'(1);
            results  <= '0;
            overflow <= 1'b0;
`ifdef EULER_SUM_COUNT_EN
            match_count <= '0;
`endif
        end else if (step) begin
            if (match) begin
                results <= sum_ext[SUM_W-1:0];
                if (sum_ext[SUM_W]) begin
                    overflow <= 1'b1;
                end
`ifdef EULER_SUM_COUNT_EN
                match_count <= match_count + CNT_W'(1);
`endif
            end
            cnt <= cnt + CNT_W'(1);
            ra  <= hit_a ? CNT_W'(1) : ra + CNT_W'(1);
            rb  <= hit_b ? CNT_W'(1) : rb + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_euler_mult_sum.sv
// Directed, table-driven bench for euler_mult_sum plus hand-written
// sequences for stalling, mid-run reset and restart from DONE.
// Honours EULER_SUM_COUNT_EN when the design is built with it.
module tb_euler_mult_sum;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SUM_W = 24;
    localparam int unsigned TIMEOUT = 20000;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             enable;
    logic [CNT_W-1:0] max_value;
    logic [CNT_W-1:0] div_a;
    logic [CNT_W-1:0] div_b;
    logic             busy;
    logic             results_valid;
    logic [SUM_W-1:0] results;
    logic             overflow;
`ifdef EULER_SUM_COUNT_EN
    logic [CNT_W-1:0] match_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    euler_mult_sum #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .enable       (enable),
        .max_value    (max_value),
        .div_a        (div_a),
        .div_b        (div_b),
        .busy         (busy),
        .results_valid(results_valid),
        .results      (results),
`ifdef EULER_SUM_COUNT_EN
        .match_count  (match_count),
`endif
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned maxv;
        int unsigned a;
        int unsigned b;
        int unsigned exp_sum;
        int unsigned exp_ovf;
        int unsigned exp_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse with the given operands; returns after the accept edge
    task automatic do_start(input int unsigned m, input int unsigned a, input int unsigned b);
        max_value = CNT_W'(m);
        div_a     = CNT_W'(a);
        div_b     = CNT_W'(b);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Wait for results_valid with enable held high; counts edges after accept
    task automatic wait_done(output int unsigned cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b0;
        while (!results_valid) begin
            if (cycles >= TIMEOUT) begin
                timed_out = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    initial begin
        int unsigned cycles;
        int unsigned en_cycles;
        int unsigned stall_busy_bad;
        int unsigned exp_lat;
        bit          to;

        vecs[0]  = '{1000,  3, 5, 233168,  0, 466};
        vecs[1]  = '{50,    7, 0, 196,     0, 7};
        vecs[2]  = '{1,     9, 9, 0,       0, 0};
        vecs[3]  = '{0,     3, 5, 0,       0, 0};
        vecs[4]  = '{10000, 3, 5, 6554452, 1, 4666};
        vecs[5]  = '{20,    1, 0, 190,     0, 19};
        vecs[6]  = '{20,    0, 0, 0,       0, 0};
        vecs[7]  = '{30,    6, 6, 60,      0, 4};
        vecs[8]  = '{16,    4, 6, 30,      0, 4};
        vecs[9]  = '{10,    3, 5, 23,      0, 4};
        vecs[10] = '{2,     1, 1, 1,       0, 1};

        reset = 1'b1; start = 1'b0; enable = 1'b1;
        max_value = '0; div_a = '0; div_b = '0;
        tick(); tick();
        check("reset_busy", busy, 0);
        check("reset_valid", results_valid, 0);
        check("reset_results", results, 0);
        check("reset_overflow", overflow, 0);
`ifdef EULER_SUM_COUNT_EN
        check("reset_match_count", match_count, 0);
`endif
        reset = 1'b0;
        tick();
        check("idle_no_start_busy", busy, 0);

        // Table-driven runs; each start is accepted from IDLE or DONE
        foreach (vecs[i]) begin
            exp_lat = (vecs[i].maxv == 0) ? 1 : vecs[i].maxv;
            do_start(vecs[i].maxv, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy_after_accept", i), busy, 1);
            check($sformatf("v%0d_valid_after_accept", i), results_valid, 0);
            wait_done(cycles, to);
            check($sformatf("v%0d_timeout", i), to, 0);
            check($sformatf("v%0d_latency", i), cycles, exp_lat);
            check($sformatf("v%0d_results", i), results, vecs[i].exp_sum);
            check($sformatf("v%0d_overflow", i), overflow, vecs[i].exp_ovf);
            check($sformatf("v%0d_busy_done", i), busy, 0);
`ifdef EULER_SUM_COUNT_EN
            check($sformatf("v%0d_match_count", i), match_count, vecs[i].exp_cnt);
`endif
            tick(); tick();
            check($sformatf("v%0d_hold_valid", i), results_valid, 1);
            check($sformatf("v%0d_hold_results", i), results, vecs[i].exp_sum);
        end

        // Enable toggled: done after exactly 10 enabled cycles, busy held while stalled
        do_start(10, 3, 5);
        en_cycles = 0;
        stall_busy_bad = 0;
        cycles = 0;
        enable = 1'b0;
        while (!results_valid && cycles < TIMEOUT) begin
            enable = ~enable;
            tick();
            cycles++;
            if (enable) en_cycles++;
            else if (!busy) stall_busy_bad++;
        end
        enable = 1'b1;
        check("stall_timeout", cycles < TIMEOUT, 1);
        check("stall_enabled_cycles", en_cycles, 10);
        check("stall_busy_low_cycles", stall_busy_bad, 0);
        check("stall_results", results, 23);
`ifdef EULER_SUM_COUNT_EN
        check("stall_match_count", match_count, 4);
`endif

        // Reset in the middle of a long run
        do_start(1000, 3, 5);
        repeat (300) tick();
        check("midrun_busy_before_reset", busy, 1);
        reset = 1'b1;
        tick();
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_results", results, 0);
        check("midrun_reset_valid", results_valid, 0);
        check("midrun_reset_overflow", overflow, 0);
        reset = 1'b0;
        tick();
        check("post_reset_idle", busy, 0);
        do_start(10, 3, 5);
        wait_done(cycles, to);
        check("post_reset_timeout", to, 0);
        check("post_reset_results", results, 23);

        // Restart from DONE, with stray starts and operand changes during the run
        do_start(16, 4, 6);
        check("restart_valid_drops", results_valid, 0);
        check("restart_results_cleared", results, 0);
        tick(); tick();
        max_value = CNT_W'(500); div_a = CNT_W'(1); div_b = CNT_W'(2);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(cycles, to);
        check("restart_timeout", to, 0);
        check("restart_latency", cycles + 5, 16);
        check("restart_results", results, 30);
        check("restart_overflow", overflow, 0);
`ifdef EULER_SUM_COUNT_EN
        check("restart_match_count", match_count, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
